// File: rtl/dfd_cla_xtrig_rx.sv
// CLA cross-trigger receiver: samples remote packets, edge-detects per enabled source,
// emits xtrigger events, counts hits, and runs the clock-halt req/ack handshake.
// Optional DFD_CLA_XTRIG_STRETCH_EN stretches each event pulse to PULSE_STRETCH cycles.
module dfd_cla_xtrig_rx #(
  parameter int NUM_SRC        = 4,
  parameter int XTRIGGER_WIDTH = 2,
  parameter int CNT_WIDTH      = 8,
  parameter int PULSE_STRETCH  = 4
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NUM_SRC*(XTRIGGER_WIDTH+1)-1:0]    net_pkt_i,
  input  logic [NUM_SRC-1:0]                       src_en_i,
  output logic [XTRIGGER_WIDTH-1:0]                xtrig_evt_o,
  input  logic                                     cnt_clear_i,
  output logic [XTRIGGER_WIDTH*CNT_WIDTH-1:0]      xtrig_cnt_o,
  output logic                                     clock_halt_req_o,
  input  logic                                     clock_halt_ack_i,
  input  logic                                     halt_release_i,
  output logic                                     halt_active_o
);

  localparam int PKT_W = XTRIGGER_WIDTH + 1;
  localparam int IN_W  = NUM_SRC * PKT_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  if (PULSE_STRETCH < 1) begin : g_param_check
    $error("PULSE_STRETCH must be >= 1");
  end

  logic [IN_W-1:0]                                 r_s1;
  logic [IN_W-1:0]                                 r_s2;
  logic [IN_W-1:0]                                 w_rise;
  logic [XTRIGGER_WIDTH-1:0]                       w_evt;
  logic                                            w_halt_rise;
  logic [XTRIGGER_WIDTH-1:0][CNT_WIDTH-1:0]        r_cnt;
  state_t                                          r_state;
  state_t                                          w_state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= net_pkt_i;
      r_s2 <= r_s1;
    end
  end

  assign w_rise = r_s1 & ~r_s2;

  // Slot 0 of each packet is clock_halt, slots 1.. are the xtrigger channels.
  always_comb begin
    w_evt       = '0;
    w_halt_rise = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_halt_rise = w_halt_rise | (src_en_i[i] & w_rise[i*PKT_W]);
      for (int c = 0; c < XTRIGGER_WIDTH; c++) begin
        w_evt[c] = w_evt[c] | (src_en_i[i] & w_rise[i*PKT_W+1+c]);
      end
    end
  end

`ifdef DFD_CLA_XTRIG_STRETCH_EN
  localparam int SW = $clog2(PULSE_STRETCH + 1);

  logic [XTRIGGER_WIDTH-1:0][SW-1:0]               r_str;

  // A new event reloads the full length, so overlapping events extend the pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_str <= '0;
    end else begin
      for (int c = 0; c < XTRIGGER_WIDTH; c++) begin
        if (w_evt[c]) begin
          r_str[c] <= SW'(PULSE_STRETCH);
        end else if (r_str[c] != '0) begin
          r_str[c] <= r_str[c] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    xtrig_evt_o = '0;
    for (int c = 0; c < XTRIGGER_WIDTH; c++) begin
      xtrig_evt_o[c] = (r_str[c] != '0);
    end
  end
`else
  logic [XTRIGGER_WIDTH-1:0]                       r_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt <= '0;
    end else begin
      r_evt <= w_evt;
    end
  end

  assign xtrig_evt_o = r_evt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      for (int c = 0; c < XTRIGGER_WIDTH; c++) begin
        if (cnt_clear_i) begin
          r_cnt[c] <= '0;
        end else if (w_evt[c] && (r_cnt[c] != {CNT_WIDTH{1'b1}})) begin
          r_cnt[c] <= r_cnt[c] + 1'b1;
        end
      end
    end
  end

  assign xtrig_cnt_o = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Halt rises seen outside IDLE are dropped on purpose; there is no pending queue.
  always_comb begin
    w_state_nxt      = r_state;
    clock_halt_req_o = 1'b0;
    halt_active_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_halt_rise) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        clock_halt_req_o = 1'b1;
        if (clock_halt_ack_i) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        clock_halt_req_o = 1'b1;
        halt_active_o    = 1'b1;
        if (halt_release_i) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!clock_halt_ack_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dfd_cla_xtrig_rx.sv
// Directed bench for dfd_cla_xtrig_rx; event pulses are checked against a cycle-stamped
// expectation queue, counters and halt handshake are checked at fixed points.
module tb_dfd_cla_xtrig_rx;

  localparam int NS = 4;
  localparam int XW = 2;
  localparam int CW = 8;
  localparam int PS = 4;

  logic              clk;
  logic              reset_n;
  logic [NS*3-1:0]   net_pkt_i;
  logic [NS-1:0]     src_en_i;
  logic [XW-1:0]     xtrig_evt_o;
  logic              cnt_clear_i;
  logic [XW*CW-1:0]  xtrig_cnt_o;
  logic              clock_halt_req_o;
  logic              clock_halt_ack_i;
  logic              halt_release_i;
  logic              halt_active_o;

  dfd_cla_xtrig_rx #(
    .NUM_SRC(NS), .XTRIGGER_WIDTH(XW), .CNT_WIDTH(CW), .PULSE_STRETCH(PS)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .net_pkt_i        (net_pkt_i),
    .src_en_i         (src_en_i),
    .xtrig_evt_o      (xtrig_evt_o),
    .cnt_clear_i      (cnt_clear_i),
    .xtrig_cnt_o      (xtrig_cnt_o),
    .clock_halt_req_o (clock_halt_req_o),
    .clock_halt_ack_i (clock_halt_ack_i),
    .halt_release_i   (halt_release_i),
    .halt_active_o    (halt_active_o)
  );

  typedef struct {
    int            cyc;
    logic [XW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ecnt  = 0;
  bit   mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Scoreboard: every nonzero event cycle must match the queue head exactly.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      while (q.size() > 0 && q[0].cyc < ecnt) begin
        n_cmp++;
        n_err++;
        $error("FAIL evt_missed: observed no pulse at cycle %0d, required %b", q[0].cyc, q[0].val);
        void'(q.pop_front());
      end
      if (xtrig_evt_o != '0) begin
        n_cmp++;
        assert (q.size() > 0 && q[0].cyc == ecnt)
        else begin
          n_err++;
          $error("FAIL evt_unexpected: observed %b at cycle %0d, required none", xtrig_evt_o, ecnt);
        end
        if (q.size() > 0 && q[0].cyc == ecnt) begin
          assert (xtrig_evt_o === q[0].val)
          else begin
            n_err++;
            $error("FAIL evt_value: observed %b at cycle %0d, required %b", xtrig_evt_o, ecnt, q[0].val);
          end
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_at(input int ofs, input logic [XW-1:0] v);
    exp_t e;
    e.cyc = ecnt + ofs;
    e.val = v;
    q.push_back(e);
  endtask

  // Input driven now is first sampled at the next edge; the event shows after the one after.
  task automatic push_pulse(input logic [XW-1:0] v);
`ifdef DFD_CLA_XTRIG_STRETCH_EN
    for (int d = 0; d < PS; d++) push_at(2 + d, v);
`else
    push_at(2, v);
`endif
  endtask

  function automatic logic [CW-1:0] cnt(input int c);
    logic [XW*CW-1:0] v;
    v = xtrig_cnt_o;
    return v[c*CW +: CW];
  endfunction

  initial begin
    reset_n          = 1'b0;
    net_pkt_i        = '0;
    src_en_i         = '0;
    cnt_clear_i      = 1'b0;
    clock_halt_ack_i = 1'b0;
    halt_release_i   = 1'b0;
    tick(3);
    chk("rst_evt", 32'(xtrig_evt_o), 0);
    chk("rst_cnt", 32'(xtrig_cnt_o), 0);
    chk("rst_req", 32'(clock_halt_req_o), 0);
    chk("rst_active", 32'(halt_active_o), 0);
    reset_n = 1'b1;
    tick(3);
    mon_en = 1'b1;
    chk("idle_evt", 32'(xtrig_evt_o), 0);
    chk("idle_cnt", 32'(xtrig_cnt_o), 0);

    // Level held high on source 0 channel 0 gives a single event.
    src_en_i     = 4'b0001;
    net_pkt_i[1] = 1'b1;
    push_pulse(2'b01);
    tick(10);
    net_pkt_i[1] = 1'b0;
    tick(8);
    chk("hold_cnt_ch0", 32'(cnt(0)), 1);
    chk("hold_cnt_ch1", 32'(cnt(1)), 0);

    // Same-cycle rises on channel 1 from sources 0 and 2, source 2 disabled.
    net_pkt_i[2] = 1'b1;
    net_pkt_i[8] = 1'b1;
    push_pulse(2'b10);
    tick(4);
    net_pkt_i[2] = 1'b0;
    net_pkt_i[8] = 1'b0;
    tick(8);
    chk("merge_dis_cnt_ch1", 32'(cnt(1)), 1);
    net_pkt_i[8] = 1'b1;
    tick(4);
    net_pkt_i[8] = 1'b0;
    tick(8);
    chk("disabled_only_cnt_ch1", 32'(cnt(1)), 1);
    src_en_i     = 4'b0101;
    net_pkt_i[2] = 1'b1;
    net_pkt_i[8] = 1'b1;
    push_pulse(2'b10);
    tick(4);
    net_pkt_i[2] = 1'b0;
    net_pkt_i[8] = 1'b0;
    tick(8);
    chk("merge_en_cnt_ch1", 32'(cnt(1)), 2);
    src_en_i = 4'b0001;

    // Saturation and clear priority; event pulses are not tracked in this stretch.
    mon_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      net_pkt_i[1] = 1'b1;
      tick(1);
      net_pkt_i[1] = 1'b0;
      tick(1);
    end
    tick(8);
    chk("sat_cnt_ch0", 32'(cnt(0)), 255);
    chk("sat_cnt_ch1", 32'(cnt(1)), 2);
    net_pkt_i[1] = 1'b1;
    tick(1);
    cnt_clear_i = 1'b1;
    tick(1);
    cnt_clear_i = 1'b0;
    chk("clear_prio_ch0", 32'(cnt(0)), 0);
    chk("clear_ch1", 32'(cnt(1)), 0);
    net_pkt_i[1] = 1'b0;
    tick(8);
    mon_en = 1'b1;

    // Halt handshake.
    net_pkt_i[0] = 1'b1;
    tick(1);
    chk("halt_req_lat", 32'(clock_halt_req_o), 0);
    tick(1);
    chk("halt_req", 32'(clock_halt_req_o), 1);
    chk("halt_req_active", 32'(halt_active_o), 0);
    halt_release_i = 1'b1;
    tick(1);
    halt_release_i = 1'b0;
    chk("rel_ignored_req", 32'(clock_halt_req_o), 1);
    chk("rel_ignored_active", 32'(halt_active_o), 0);
    tick(3);
    clock_halt_ack_i = 1'b1;
    tick(1);
    chk("halted_active", 32'(halt_active_o), 1);
    chk("halted_req", 32'(clock_halt_req_o), 1);
    net_pkt_i[0] = 1'b0;
    tick(2);
    net_pkt_i[0] = 1'b1;
    tick(3);
    chk("halted_rise_ignored", 32'(halt_active_o), 1);
    halt_release_i = 1'b1;
    tick(1);
    halt_release_i = 1'b0;
    chk("release_req", 32'(clock_halt_req_o), 0);
    chk("release_active", 32'(halt_active_o), 0);
    tick(3);
    chk("release_hold_req", 32'(clock_halt_req_o), 0);
    clock_halt_ack_i = 1'b0;
    tick(2);
    net_pkt_i[0] = 1'b0;
    tick(2);
    net_pkt_i[0] = 1'b1;
    tick(2);
    chk("rereq_req", 32'(clock_halt_req_o), 1);

    // Asynchronous reset in REQ drops req without a clock edge.
    net_pkt_i = '0;
    reset_n   = 1'b0;
    #1;
    chk("async_rst_req", 32'(clock_halt_req_o), 0);
    chk("async_rst_active", 32'(halt_active_o), 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_req", 32'(clock_halt_req_o), 0);
    chk("post_rst_cnt", 32'(xtrig_cnt_o), 0);

    // Single rise, then two rises two cycles apart.
    net_pkt_i[1] = 1'b1;
    push_pulse(2'b01);
    tick(1);
    net_pkt_i[1] = 1'b0;
    tick(8);
    chk("single_cnt_ch0", 32'(cnt(0)), 1);
    cnt_clear_i = 1'b1;
    tick(1);
    cnt_clear_i = 1'b0;
    chk("clear_cnt_ch0", 32'(cnt(0)), 0);
    net_pkt_i[1] = 1'b1;
`ifdef DFD_CLA_XTRIG_STRETCH_EN
    for (int d = 2; d < 8; d++) push_at(d, 2'b01);
`else
    push_at(2, 2'b01);
    push_at(4, 2'b01);
`endif
    tick(1);
    net_pkt_i[1] = 1'b0;
    tick(1);
    net_pkt_i[1] = 1'b1;
    tick(1);
    net_pkt_i[1] = 1'b0;
    tick(10);
    chk("double_cnt_ch0", 32'(cnt(0)), 2);
    chk("double_cnt_ch1", 32'(cnt(1)), 0);

    tick(2);
    chk("evt_queue_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
